// File: rtl/serial_add_pkg.sv
// Shared types and sizing helpers for the bit-serial adder.
// Optional signed-overflow output: SERIAL_ADD_OVF_EN.
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam int WIDTH_DEF = 4;

  // Counter must reach WIDTH-1; never narrower than one bit.
  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

  localparam int CNT_W_DEF = cnt_width(WIDTH_DEF);

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Start/result bundle: master drives start, a, b, ci;
// slave returns busy, done, s, co (and ovf with SERIAL_ADD_OVF_EN).
interface serial_add_ctrl_if #(
  parameter int WIDTH = 4
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ci;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;
  logic             co;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf;
`endif

  modport master (
    output start, a, b, ci,
`ifdef SERIAL_ADD_OVF_EN
    input  ovf,
`endif
    input  busy, done, s, co
  );

  modport slave (
    input  start, a, b, ci,
`ifdef SERIAL_ADD_OVF_EN
    output ovf,
`endif
    output busy, done, s, co
  );

endinterface

// File: rtl/fa.sv
// One-bit full adder cell.
// Ports: a, b, ci in; co, s out.
module fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic co,
  output logic s
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one fa cell, LSB first, WIDTH cycles per add.
// Ports: clk, rst (sync, high), bus (slave); ovf via SERIAL_ADD_OVF_EN.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input logic              clk,
  input logic              rst,
  serial_add_ctrl_if.slave bus
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t state_q, state_d;

  logic [WIDTH-1:0] a_q, b_q;
  // Low sum bits so far; the bit in flight comes from fa.
  logic [WIDTH-1:1] r_q;
  logic [WIDTH-1:0] r_d;
  logic [CW-1:0]    cnt_q;
  logic             carry_q;
  logic [WIDTH-1:0] s_q;
  logic             co_q;
  logic             fa_s, fa_co;
  logic             accept, running, last;

  fa u_fa (
    .a  (a_q[0]),
    .b  (b_q[0]),
    .ci (carry_q),
    .co (fa_co),
    .s  (fa_s)
  );

  assign running = (state_q == RUN);
  assign accept  = !running && bus.start;
  assign last    = running && (cnt_q == LAST);
  assign r_d     = {fa_s, r_q};

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (last) state_d = DONE;
      DONE:    state_d = bus.start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      s_q     <= '0;
      co_q    <= 1'b0;
    end else if (accept) begin
      a_q     <= bus.a;
      b_q     <= bus.b;
      carry_q <= bus.ci;
      cnt_q   <= '0;
      r_q     <= '0;
    end else if (running) begin
      a_q     <= {1'b0, a_q[WIDTH-1:1]};
      b_q     <= {1'b0, b_q[WIDTH-1:1]};
      r_q     <= r_d[WIDTH-1:1];
      carry_q <= fa_co;
      cnt_q   <= cnt_q + CW'(1);
      if (last) begin
        s_q  <= r_d;
        co_q <= fa_co;
      end
    end
  end

`ifdef SERIAL_ADD_OVF_EN
  logic ovf_q;

  // On the last RUN cycle carry_q is the carry into the MSB.
  always_ff @(posedge clk) begin
    if (rst)       ovf_q <= 1'b0;
    else if (last) ovf_q <= carry_q ^ fa_co;
  end

  assign bus.ovf = ovf_q;
`endif

  assign bus.busy = running;
  assign bus.done = (state_q == DONE);
  assign bus.s    = s_q;
  assign bus.co   = co_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed plus random checks of serial_add_ctrl at WIDTH=4.
// Build with SERIAL_ADD_OVF_EN to include the ovf checks.
module tb_serial_add_ctrl;

  localparam int W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;

  logic [W-1:0] m_s = '0;
  logic         m_co = 1'b0;
  logic         m_ovf = 1'b0;

  serial_add_ctrl_if #(.WIDTH(W)) bus ();

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic e_busy,
                          input logic e_done);
    chk({tag, ".busy"}, 32'(bus.busy), 32'(e_busy));
    chk({tag, ".done"}, 32'(bus.done), 32'(e_done));
    chk({tag, ".s"}, 32'(bus.s), 32'(m_s));
    chk({tag, ".co"}, 32'(bus.co), 32'(m_co));
`ifdef SERIAL_ADD_OVF_EN
    chk({tag, ".ovf"}, 32'(bus.ovf), 32'(m_ovf));
`endif
  endtask

  task automatic idle(input int n);
    bus.start = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk_outs("idle", 1'b0, 1'b0);
    end
  endtask

  // Issue one add; returns at the negedge inside the done cycle.
  task automatic run_op(input int a, input int b, input int ci,
                        input bit noise);
    int sum, sa, sb, ss;
    sum = (a + b + ci) % (1 << (W + 1));
    sa  = (a >= (1 << (W - 1))) ? a - (1 << W) : a;
    sb  = (b >= (1 << (W - 1))) ? b - (1 << W) : b;
    ss  = sa + sb + ci;
    bus.start = 1'b1;
    bus.a     = W'(a);
    bus.b     = W'(b);
    bus.ci    = ci[0];
    @(negedge clk);
    bus.start = 1'b0;
    for (int k = 1; k <= W; k++) begin
      chk_outs("run", 1'b1, 1'b0);
      if (noise) begin
        bus.start = 1'($urandom);
        bus.a     = W'($urandom);
        bus.b     = W'($urandom);
        bus.ci    = 1'($urandom);
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    m_s   = W'(sum);
    m_co  = sum[W];
    m_ovf = (ss > (1 << (W - 1)) - 1) || (ss < -(1 << (W - 1)));
    chk_outs("done", 1'b0, 1'b1);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.ci    = 1'b0;
    rst       = 1'b1;
    repeat (2) @(negedge clk);
    chk_outs("reset", 1'b0, 1'b0);
    rst = 1'b0;
    idle(1);

    run_op(3, 5, 0, 0);
    chk("basic.s", 32'(bus.s), 32'd8);
    idle(1);
    run_op(15, 1, 0, 0);
    chk("cout.co", 32'(bus.co), 32'd1);
    idle(1);
`ifdef SERIAL_ADD_OVF_EN
    run_op(7, 1, 0, 0);
    chk("ovf.flag", 32'(bus.ovf), 32'd1);
    idle(1);
`endif
    run_op(7, 7, 1, 1);
    chk("cin.s", 32'(bus.s), 32'd15);
    idle(2);

    bus.start = 1'b1;
    bus.a     = W'(5);
    bus.b     = W'(6);
    bus.ci    = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk_outs("midrst.run", 1'b1, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst   = 1'b0;
    m_s   = '0;
    m_co  = 1'b0;
    m_ovf = 1'b0;
    chk_outs("midrst.clr", 1'b0, 1'b0);
    idle(6);
    run_op(2, 2, 0, 0);
    idle(1);

    run_op(1, 6, 0, 0);
    run_op(9, 9, 0, 0);
    chk("b2b.co", 32'(bus.co), 32'd1);
    idle(1);

    for (int i = 0; i < 24; i++) begin
      run_op(int'($urandom_range(15)), int'($urandom_range(15)),
             int'($urandom_range(1)), bit'($urandom_range(1)));
      idle(int'($urandom_range(2)));
    end
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
